// File: rtl/mcdt_rx.sv
// rtl/mcdt_rx.sv - mcdt stream demultiplexer into three show-ahead channel FIFOs
// Optional sequence checker enabled by defining MCDT_RX_SEQCHK_EN.
module mcdt_rx #(
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [31:0]   mcdt_data_i,
    input  logic          mcdt_val_i,
    input  logic [1:0]    mcdt_id_i,
    output logic [31:0]   ch0_data_o,
    output logic          ch0_valid_o,
    input  logic          ch0_ready_i,
    output logic [CW-1:0] ch0_count_o,
    output logic [31:0]   ch1_data_o,
    output logic          ch1_valid_o,
    input  logic          ch1_ready_i,
    output logic [CW-1:0] ch1_count_o,
    output logic [31:0]   ch2_data_o,
    output logic          ch2_valid_o,
    input  logic          ch2_ready_i,
    output logic [CW-1:0] ch2_count_o,
    output logic [2:0]    overflow_o,
    output logic          id_err_o,
    output logic [2:0]    seq_err_o,
    input  logic          err_clr_i
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]          rdy_w;
    logic [2:0]          acc_w;
    logic [2:0]          drop_w;
    logic [2:0][31:0]    head_w;
    logic [2:0][CW-1:0]  cnt_w;
    logic [2:0]          overflow_q;
    logic                id_err_q;
`ifdef MCDT_RX_SEQCHK_EN
    logic [2:0]          seq_set_w;
    logic [2:0]          seq_err_q;
`endif

    assign rdy_w = {ch2_ready_i, ch1_ready_i, ch0_ready_i};

    for (genvar g = 0; g < 3; g++) begin : g_ch
        logic [31:0]   mem_q [DEPTH];
        logic [AW-1:0] wp_q;
        logic [AW-1:0] rp_q;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          wr;
        logic          pop;
        logic          full;

        assign wr        = mcdt_val_i && (mcdt_id_i == 2'(g));
        assign pop       = (cnt_q != '0) && rdy_w[g];
        assign full      = (cnt_q == CW'(DEPTH));
        // A pop on the same edge frees the slot, so a full FIFO can still accept.
        assign acc_w[g]  = wr && (!full || pop);
        assign drop_w[g] = wr && full && !pop;

        always_comb begin
            cnt_d = cnt_q;
            if (acc_w[g] && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (!acc_w[g] && pop) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (acc_w[g]) begin
                mem_q[wp_q] <= mcdt_data_i;
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wp_q  <= '0;
                rp_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (acc_w[g]) begin
                    wp_q <= wp_q + 1'b1;
                end
                if (pop) begin
                    rp_q <= rp_q + 1'b1;
                end
                cnt_q <= cnt_d;
            end
        end

        assign head_w[g] = (cnt_q != '0) ? mem_q[rp_q] : 32'h0;
        assign cnt_w[g]  = cnt_q;

`ifdef MCDT_RX_SEQCHK_EN
        logic [15:0] exp_q;
        logic        init_q;

        // A word accepted on a clear cycle re-seeds the expectation instead of being checked.
        assign seq_set_w[g] = acc_w[g] && init_q && !err_clr_i &&
                              (mcdt_data_i[15:0] != exp_q);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                exp_q  <= '0;
                init_q <= 1'b0;
            end else if (acc_w[g]) begin
                exp_q  <= mcdt_data_i[15:0] + 16'd1;
                init_q <= 1'b1;
            end else if (err_clr_i) begin
                init_q <= 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q <= '0;
            id_err_q   <= 1'b0;
        end else begin
            overflow_q <= (err_clr_i ? 3'b000 : overflow_q) | drop_w;
            id_err_q   <= (err_clr_i ? 1'b0 : id_err_q) | (mcdt_val_i && (mcdt_id_i == 2'd3));
        end
    end

`ifdef MCDT_RX_SEQCHK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq_err_q <= '0;
        end else begin
            seq_err_q <= (err_clr_i ? 3'b000 : seq_err_q) | seq_set_w;
        end
    end
    assign seq_err_o = seq_err_q;
`else
    assign seq_err_o = 3'b000;
`endif

    assign ch0_data_o  = head_w[0];
    assign ch1_data_o  = head_w[1];
    assign ch2_data_o  = head_w[2];
    assign ch0_count_o = cnt_w[0];
    assign ch1_count_o = cnt_w[1];
    assign ch2_count_o = cnt_w[2];
    assign ch0_valid_o = (cnt_w[0] != '0);
    assign ch1_valid_o = (cnt_w[1] != '0);
    assign ch2_valid_o = (cnt_w[2] != '0);
    assign overflow_o  = overflow_q;
    assign id_err_o    = id_err_q;
endmodule
